// File: rtl/keypad_entry_scanner.sv
// keypad_entry_scanner
// Scans a ROWS x COLS matrix keypad one row at a time, debounces press and
// release, encodes one key per press as row*COLS+col and accumulates BCD
// digits with clear / backspace / enter editing. entry_state is a one-hot
// copy of digit_count for the entry-progress LEDs.
// Optional build macro: KEYPAD_AUTOREPEAT_EN (auto-repeat of a held key).
module keypad_entry_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int DIGITS   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COLS-1:0]              col_in,
    output logic [ROWS-1:0]              row_out,
    output logic [$clog2(ROWS*COLS)-1:0] key_code,
    output logic                         key_valid,
    output logic [4*DIGITS-1:0]          value_out,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         done,
    output logic                         overflow,
    output logic [DIGITS:0]              entry_state
);

    localparam int KW   = $clog2(ROWS * COLS);
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int VW   = 4 * DIGITS;
    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DBW  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t          state_r;
    logic [DIVW-1:0] div_cnt_r;
    logic [RW-1:0]   row_idx_r;
    logic [CLW-1:0]  lat_col_r;
    logic [DBW-1:0]  deb_cnt_r;
    logic            after_done_r;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [4:0]      rep_cnt_r;
`endif

    logic            strobe_s;
    logic [COLS-1:0] active_s;
    logic            any_s;
    logic [CLW-1:0]  low_col_s;
    logic            lat_active_s;
    logic [31:0]     code_s;

    // Lowest-index active column wins when several are closed
    function automatic logic [CLW-1:0] lowest_col(input logic [COLS-1:0] act);
        logic [CLW-1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (act[i]) begin
                idx = CLW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
        return (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
    endfunction

    // One-cold drive pattern for a given row
    function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] r);
        logic [ROWS-1:0] pat;
        pat    = '1;
        pat[r] = 1'b0;
        return pat;
    endfunction

    function automatic logic [KW-1:0] encode_key(input logic [RW-1:0] r, input logic [CLW-1:0] c);
        logic [31:0] full;
        full = 32'(r) * 32'(COLS) + 32'(c);
        return full[KW-1:0];
    endfunction

    function automatic logic [DIGITS:0] one_hot(input logic [CW-1:0] n);
        logic [DIGITS:0] oh;
        oh    = '0;
        oh[n] = 1'b1;
        return oh;
    endfunction

    assign strobe_s     = (div_cnt_r == DIVW'(SCAN_DIV - 1));
    assign active_s     = ~col_in;
    assign any_s        = |active_s;
    assign low_col_s    = lowest_col(active_s);
    assign lat_active_s = active_s[lat_col_r];
    assign code_s       = 32'(key_code);

    // Dwell counter, row scan and press/release debounce state machine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_SCAN;
            div_cnt_r <= '0;
            row_idx_r <= '0;
            row_out   <= {{(ROWS-1){1'b1}}, 1'b0};
            lat_col_r <= '0;
            deb_cnt_r <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_r <= 5'd0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (strobe_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DIVW'(1);
            end
            if (strobe_s) begin
                case (state_r)
                    ST_SCAN: begin
                        if (any_s) begin
                            lat_col_r <= low_col_s;
                            if (DEBOUNCE <= 1) begin
                                key_code  <= encode_key(row_idx_r, low_col_s);
                                key_valid <= 1'b1;
                                deb_cnt_r <= '0;
                                state_r   <= ST_HELD;
                            end else begin
                                deb_cnt_r <= DBW'(1);
                                state_r   <= ST_DEBOUNCE;
                            end
                        end else begin
                            row_idx_r <= next_row(row_idx_r);
                            row_out   <= row_drive(next_row(row_idx_r));
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!lat_active_s) begin
                            state_r   <= ST_SCAN;
                            row_idx_r <= next_row(row_idx_r);
                            row_out   <= row_drive(next_row(row_idx_r));
                        end else if (deb_cnt_r + DBW'(1) == DBW'(DEBOUNCE)) begin
                            key_code  <= encode_key(row_idx_r, lat_col_r);
                            key_valid <= 1'b1;
                            deb_cnt_r <= '0;
                            state_r   <= ST_HELD;
                        end else begin
                            deb_cnt_r <= deb_cnt_r + DBW'(1);
                        end
                    end
                    ST_HELD: begin
                        if (lat_active_s) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            // First repeat after 16 held samples, then every 4
                            deb_cnt_r <= '0;
                            if (rep_cnt_r == 5'd15 || rep_cnt_r == 5'd19) begin
                                key_valid <= 1'b1;
                                rep_cnt_r <= 5'd16;
                            end else begin
                                rep_cnt_r <= rep_cnt_r + 5'd1;
                            end
`else
                            deb_cnt_r <= '0;
`endif
                        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_r <= 5'd0;
`endif
                            if (deb_cnt_r + DBW'(1) == DBW'(DEBOUNCE)) begin
                                deb_cnt_r <= '0;
                                state_r   <= ST_SCAN;
                                row_idx_r <= next_row(row_idx_r);
                                row_out   <= row_drive(next_row(row_idx_r));
                            end else begin
                                deb_cnt_r <= deb_cnt_r + DBW'(1);
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    // BCD accumulator and editing, applied the cycle after each accepted key
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_out    <= '0;
            digit_count  <= '0;
            entry_state  <= {{DIGITS{1'b0}}, 1'b1};
            done         <= 1'b0;
            overflow     <= 1'b0;
            after_done_r <= 1'b0;
        end else begin
            done <= 1'b0;
            if (key_valid) begin
                if (code_s <= 32'd9) begin
                    if (after_done_r) begin
                        value_out    <= VW'(code_s[3:0]);
                        digit_count  <= CW'(1);
                        entry_state  <= one_hot(CW'(1));
                        overflow     <= 1'b0;
                        after_done_r <= 1'b0;
                    end else if (digit_count < CW'(DIGITS)) begin
                        value_out   <= (value_out << 4) | VW'(code_s[3:0]);
                        digit_count <= digit_count + CW'(1);
                        entry_state <= one_hot(digit_count + CW'(1));
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (code_s == 32'd10) begin
                    value_out    <= '0;
                    digit_count  <= '0;
                    entry_state  <= one_hot(CW'(0));
                    overflow     <= 1'b0;
                    after_done_r <= 1'b0;
                end else if (code_s == 32'd11) begin
                    after_done_r <= 1'b0;
                    if (digit_count != CW'(0)) begin
                        value_out   <= value_out >> 4;
                        digit_count <= digit_count - CW'(1);
                        entry_state <= one_hot(digit_count - CW'(1));
                    end else begin
                        value_out <= value_out;
                    end
                end else if (code_s == 32'd12) begin
                    done         <= 1'b1;
                    after_done_r <= 1'b1;
                end else begin
                    after_done_r <= after_done_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner (SCAN_DIV=4, DEBOUNCE=2, DIGITS=4).
// A keypad model closes keys on the driven row; an editing model keeps the
// entered digits as a list and is compared with the DUT every cycle.
module tb_keypad_entry_scanner;

    localparam int DIG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] value_out;
    logic [2:0]  digit_count;
    logic        done;
    logic        overflow;
    logic [4:0]  entry_state;

    logic [15:0] keys      = 16'h0000;
    logic [3:0]  col_force = 4'h0;

    int tests = 0;
    int failed = 0;
    int kv_pulses = 0;
    int done_pulses = 0;
    int exp_q[$];
    int m_digits[$];
    bit m_over = 1'b0;
    bit m_after_done = 1'b0;
    bit exp_done_next = 1'b0;

    keypad_entry_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .DIGITS(4)
    ) dut (
        .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
        .key_code(key_code), .key_valid(key_valid), .value_out(value_out),
        .digit_count(digit_count), .done(done), .overflow(overflow),
        .entry_state(entry_state)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a closed key pulls its column low while its row is driven
    always_comb begin
        col_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
            if (col_force[c]) col_in[c] = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_value();
        int v;
        v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v[15:0];
    endfunction

    task automatic model_apply(input int code);
        if (code <= 9) begin
            if (m_after_done) begin
                m_digits.delete();
                m_over = 1'b0;
                m_after_done = 1'b0;
            end
            if (m_digits.size() < DIG) m_digits.push_back(code);
            else m_over = 1'b1;
        end else if (code == 10) begin
            m_digits.delete();
            m_over = 1'b0;
            m_after_done = 1'b0;
        end else if (code == 11) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
            m_after_done = 1'b0;
        end else if (code == 12) begin
            m_after_done = 1'b1;
        end
        exp_done_next = (code == 12);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int code;
        if (!rst) begin
            exp_q.delete();
            m_digits.delete();
            m_over = 1'b0;
            m_after_done = 1'b0;
            exp_done_next = 1'b0;
        end else begin
            chk("row_onecold", 32'($countones(~row_out)), 32'd1);
            chk("done", 32'(done), 32'(exp_done_next));
            chk("value", 32'(value_out), 32'(model_value()));
            chk("count", 32'(digit_count), 32'(m_digits.size()));
            chk("entry", 32'(entry_state), 32'(1) << m_digits.size());
            chk("overflow", 32'(overflow), 32'(m_over));
            if (done) done_pulses++;
            if (key_valid) begin
                kv_pulses++;
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_key: got code %0d expected no key_valid at %0t", key_code, $time);
                    exp_done_next = 1'b0;
                end else begin
                    code = exp_q.pop_front();
                    chk("key_code", 32'(key_code), 32'(code));
                    model_apply(code);
                end
            end else begin
                exp_done_next = 1'b0;
            end
        end
    end

    task automatic chk_reset_values();
        chk("rst_row", 32'(row_out), 32'h0000000E);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_value", 32'(value_out), 32'd0);
        chk("rst_count", 32'(digit_count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_entry", 32'(entry_state), 32'd1);
    endtask

    task automatic press(input logic [15:0] mask, input int code);
        exp_q.push_back(code);
        keys = mask;
        repeat (40) @(negedge clk);
        keys = 16'h0000;
        repeat (16) @(negedge clk);
        chk("key_missing", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_row(input logic [3:0] pat);
        logic [3:0] prev;
        bit ok;
        int n;
        prev = row_out;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 64) begin
            @(negedge clk);
            if (row_out == pat && prev != pat) ok = 1'b1;
            prev = row_out;
            n++;
        end
        chk("row_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kv_cyc;
        int k0;
        int d0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values();

        // Key 6 (row1/col2) pressed straight out of reset
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(6);
        keys = 16'h0040;
        kv_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_valid && kv_cyc == 0) kv_cyc = i;
        end
        chk("kv_latency", 32'(kv_cyc), 32'd12);
        keys = 16'h0000;
        repeat (16) @(negedge clk);
        chk("key_missing", 32'(exp_q.size()), 32'd0);
        chk("t1_value", 32'(value_out), 32'h0006);
        chk("t1_count", 32'(digit_count), 32'd1);
        chk("t1_entry", 32'(entry_state), 32'b00010);
        chk("t1_pulses", 32'(kv_pulses), 32'd1);

        // Clear, 1..5 (fifth overflows), enter
        press(16'h0400, 10);
        for (int d = 1; d <= 5; d++) press(16'(1) << d, d);
        chk("t2_value", 32'(value_out), 32'h1234);
        chk("t2_ovf", 32'(overflow), 32'd1);
        d0 = done_pulses;
        press(16'h1000, 12);
        chk("t2_done_cnt", 32'(done_pulses - d0), 32'd1);
        chk("t2_value_kept", 32'(value_out), 32'h1234);
        chk("t2_entry", 32'(entry_state), 32'b10000);

        // Digit after enter restarts the entry; backspace saturates at zero
        press(16'h0080, 7);
        chk("t3_after_done", 32'(value_out), 32'h0007);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        press(16'h0100, 8);
        chk("t3_78", 32'(value_out), 32'h0078);
        press(16'h0800, 11);
        chk("t3_bs1", 32'(value_out), 32'h0007);
        press(16'h0800, 11);
        chk("t3_bs2", 32'(value_out), 32'h0000);
        press(16'h0800, 11);
        chk("t3_bs3_count", 32'(digit_count), 32'd0);
        chk("t3_bs3_entry", 32'(entry_state), 32'd1);

        // One-sample glitch on col0 at the row0 sample point
        k0 = kv_pulses;
        wait_row(4'b1110);
        repeat (3) @(negedge clk);
        col_force = 4'b0001;
        @(negedge clk);
        col_force = 4'b0000;
        chk("glitch_row_held", 32'(row_out), 32'h0000000E);
        repeat (4) @(negedge clk);
        chk("glitch_row1", 32'(row_out), 32'h0000000D);
        repeat (20) @(negedge clk);
        chk("glitch_no_key", 32'(kv_pulses), 32'(k0));

        // Two columns on row2: lowest column wins
        press(16'h0A00, 9);
        chk("t5_code", 32'(key_code), 32'd9);
        chk("t5_value", 32'(value_out), 32'h0009);

        // Reset while the same press is being debounced
        wait_row(4'b1101);
        keys = 16'h0A00;
        wait_row(4'b1011);
        repeat (4) @(negedge clk);
        chk("t5_row_held", 32'(row_out), 32'h0000000B);
        k0 = kv_pulses;
        #1 rst = 1'b0;
        #1;
        chk_reset_values();
        keys = 16'h0000;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_no_pulse", 32'(kv_pulses), 32'(k0));

        // Enter with nothing entered still pulses done with value 0
        d0 = done_pulses;
        press(16'h1000, 12);
        chk("t6_done_cnt", 32'(done_pulses - d0), 32'd1);
        chk("t6_value", 32'(value_out), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
